// File: rtl/complex_rbv_pkg.sv
// Shared types and constants for the complex row-by-vector scheduler.
// Holds the state encoding, the tag field layout and the default latencies shared with the datapath.
package complex_rbv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_t;

    // Tag layout: {row, last, first, valid}, with valid in bit 0
    localparam int TAG_VALID_BIT = 0;
    localparam int TAG_FIRST_BIT = 1;
    localparam int TAG_LAST_BIT  = 2;
    localparam int TAG_ROW_LSB   = 3;
    localparam int TAG_CTRL_W    = 3;

    localparam int DEFAULT_MEM_LAT = 1;
    localparam int DEFAULT_DP_LAT  = 9;

    function automatic int tag_width(input int row_w);
        return TAG_CTRL_W + row_w;
    endfunction

endpackage

// File: rtl/rbv_tag_pipe.sv
// Shift register that carries issue tags alongside the RAM read and the datapath latency.
// Provides a mid-pipe valid tap, the final-stage tag, and a flag for entries still in flight.
module rbv_tag_pipe
    import complex_rbv_pkg::*;
#(
    parameter int TAG_W = 11,
    parameter int DEPTH = 10,
    parameter int TAP   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [TAG_W-1:0] tag_in,
    output logic             tap_valid,
    output logic [TAG_W-1:0] out_tag,
    output logic             pending
);

    logic [TAG_W-1:0] stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    generate
        if (TAP == 0) begin : g_tap_direct
            assign tap_valid = tag_in[TAG_VALID_BIT];
        end else begin : g_tap_stage
            assign tap_valid = stage_q[TAP-1][TAG_VALID_BIT];
        end
    endgenerate

    assign out_tag = stage_q[DEPTH-1];

    // The final stage is excluded: it drains on the next edge, so the scheduler can finish in step with it
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            pending = pending | stage_q[i][TAG_VALID_BIT];
        end
    end

endmodule

// File: rtl/complex_row_by_vector_scheduler.sv
// Issues 192b chunk reads row by row for a complex matrix-by-vector product and tags the datapath results.
// Optional issue stall input is enabled with the RBV_SCHED_STALL_EN macro.
module complex_row_by_vector_scheduler
    import complex_rbv_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int ROW_W   = 8,
    parameter int CHUNK_W = 6,
    parameter int MEM_LAT = DEFAULT_MEM_LAT,
    parameter int DP_LAT  = DEFAULT_DP_LAT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ROW_W-1:0]   num_rows,
    input  logic [CHUNK_W-1:0] chunks_per_row,
`ifdef RBV_SCHED_STALL_EN
    input  logic               stall,
`endif
    output logic               busy,
    output logic               done,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  a_rd_addr,
    output logic [ADDR_W-1:0]  p_rd_addr,
    output logic               start_row_by_vector,
    output logic               partial_valid,
    output logic               partial_first,
    output logic               partial_last,
    output logic [ROW_W-1:0]   partial_row
);

    localparam int TAG_W = tag_width(ROW_W);
    localparam int DEPTH = MEM_LAT + DP_LAT;

    sched_state_t       state_q, state_d;
    logic [ROW_W-1:0]   cfg_rows;
    logic [CHUNK_W-1:0] cfg_chunks;
    logic [ROW_W-1:0]   row_cnt;
    logic [CHUNK_W-1:0] chunk_cnt;
    logic [ADDR_W-1:0]  addr_cnt;
    logic               accept;
    logic               hold;
    logic               cfg_ok;
    logic               last_chunk;
    logic               last_row;
    logic               pending;
    logic [TAG_W-1:0]   tag_in;
    logic [TAG_W-1:0]   out_tag;

`ifdef RBV_SCHED_STALL_EN
    assign hold = stall;
`else
    assign hold = 1'b0;
`endif

    assign cfg_ok     = (num_rows != '0) && (chunks_per_row != '0);
    assign last_chunk = (chunk_cnt == cfg_chunks - CHUNK_W'(1));
    assign last_row   = (row_cnt == cfg_rows - ROW_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b1;
        done    = 1'b0;
        rd_en   = 1'b0;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (cfg_ok) begin
                        accept  = 1'b1;
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_ISSUE: begin
                if (!hold) begin
                    rd_en = 1'b1;
                    if (last_chunk && last_row) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!pending) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The A address is a free-running linear count, equal to row*chunks_per_row + chunk modulo 2^ADDR_W
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_rows   <= '0;
            cfg_chunks <= '0;
            row_cnt    <= '0;
            chunk_cnt  <= '0;
            addr_cnt   <= '0;
        end else if (accept) begin
            cfg_rows   <= num_rows;
            cfg_chunks <= chunks_per_row;
            row_cnt    <= '0;
            chunk_cnt  <= '0;
            addr_cnt   <= '0;
        end else if (rd_en) begin
            addr_cnt <= addr_cnt + ADDR_W'(1);
            if (last_chunk) begin
                chunk_cnt <= '0;
                row_cnt   <= row_cnt + ROW_W'(1);
            end else begin
                chunk_cnt <= chunk_cnt + CHUNK_W'(1);
            end
        end
    end

    always_comb begin
        tag_in                          = '0;
        tag_in[TAG_VALID_BIT]           = rd_en;
        tag_in[TAG_FIRST_BIT]           = rd_en && (chunk_cnt == '0);
        tag_in[TAG_LAST_BIT]            = rd_en && last_chunk;
        tag_in[TAG_ROW_LSB +: ROW_W]    = rd_en ? row_cnt : '0;
    end

    rbv_tag_pipe #(
        .TAG_W (TAG_W),
        .DEPTH (DEPTH),
        .TAP   (MEM_LAT)
    ) u_tag_pipe (
        .clk       (clk),
        .reset     (reset),
        .tag_in    (tag_in),
        .tap_valid (start_row_by_vector),
        .out_tag   (out_tag),
        .pending   (pending)
    );

    assign a_rd_addr     = addr_cnt;
    assign p_rd_addr     = ADDR_W'(chunk_cnt);
    assign partial_valid = out_tag[TAG_VALID_BIT];
    assign partial_first = out_tag[TAG_FIRST_BIT];
    assign partial_last  = out_tag[TAG_LAST_BIT];
    assign partial_row   = out_tag[TAG_ROW_LSB +: ROW_W];

endmodule

// File: tb/tb_complex_row_by_vector_scheduler.sv
// Directed self-checking bench for complex_row_by_vector_scheduler (MEM_LAT=1, DP_LAT=9).
// Stall scenario is compiled in only when RBV_SCHED_STALL_EN is defined.
module tb_complex_row_by_vector_scheduler;

    localparam int WINDOW = 40;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] num_rows;
    logic [5:0] chunks_per_row;
`ifdef RBV_SCHED_STALL_EN
    logic       stall;
`endif
    logic       busy, done, rd_en, start_row_by_vector;
    logic [9:0] a_rd_addr, p_rd_addr;
    logic       partial_valid, partial_first, partial_last;
    logic [7:0] partial_row;

    int tests_run = 0;
    int tests_failed = 0;

    int rd_cycles[$], a_q[$], p_q[$], srbv_cycles[$];
    int pv_cycles[$], pf_q[$], pl_q[$], pr_q[$];
    int done_cycle, done_count;
    int busy_at[0:63];
    int addr_at[0:63];
    int rd_at[0:63];
    int snap_ctrl, snap_addr;

    always #5 clk = ~clk;

    complex_row_by_vector_scheduler dut (
        .clk                 (clk),
        .reset               (reset),
        .start               (start),
        .num_rows            (num_rows),
        .chunks_per_row      (chunks_per_row),
`ifdef RBV_SCHED_STALL_EN
        .stall               (stall),
`endif
        .busy                (busy),
        .done                (done),
        .rd_en               (rd_en),
        .a_rd_addr           (a_rd_addr),
        .p_rd_addr           (p_rd_addr),
        .start_row_by_vector (start_row_by_vector),
        .partial_valid       (partial_valid),
        .partial_first       (partial_first),
        .partial_last        (partial_last),
        .partial_row         (partial_row)
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int qget(input int q[$], input int k);
        return (k < q.size()) ? q[k] : -1;
    endfunction

    // Start is high in cycle 0; cycle t samples are taken on the falling edge inside cycle t
    task automatic applyStimulus(input int rows, input int chunks, input int repulse_cycle,
                                 input int reset_cycle, input int stall_start, input int stall_len);
        rd_cycles.delete(); a_q.delete(); p_q.delete(); srbv_cycles.delete();
        pv_cycles.delete(); pf_q.delete(); pl_q.delete(); pr_q.delete();
        done_cycle = -1;
        done_count = 0;
        snap_ctrl  = -1;
        snap_addr  = -1;
        @(posedge clk); #1;
        num_rows       = 8'(rows);
        chunks_per_row = 6'(chunks);
        start          = 1'b1;
        for (int t = 1; t <= WINDOW; t++) begin
            @(posedge clk); #1;
            start = (t == repulse_cycle);
            if (t == repulse_cycle) begin
                num_rows       = 8'd5;
                chunks_per_row = 6'd7;
            end
            reset = (t == reset_cycle);
`ifdef RBV_SCHED_STALL_EN
            stall = (t >= stall_start) && (t < stall_start + stall_len);
`endif
            @(negedge clk);
            busy_at[t] = int'(busy);
            addr_at[t] = int'(a_rd_addr);
            rd_at[t]   = int'(rd_en);
            if (rd_en) begin
                rd_cycles.push_back(t);
                a_q.push_back(int'(a_rd_addr));
                p_q.push_back(int'(p_rd_addr));
            end
            if (start_row_by_vector) srbv_cycles.push_back(t);
            if (partial_valid) begin
                pv_cycles.push_back(t);
                pf_q.push_back(int'(partial_first));
                pl_q.push_back(int'(partial_last));
                pr_q.push_back(int'(partial_row));
            end
            if (done) begin
                done_count++;
                if (done_cycle < 0) done_cycle = t;
            end
            if (reset_cycle > 0 && t == reset_cycle + 1) begin
                snap_ctrl = int'({busy, done, rd_en, start_row_by_vector, partial_valid,
                                  partial_first, partial_last});
                snap_addr = int'({a_rd_addr, p_rd_addr});
            end
        end
`ifdef RBV_SCHED_STALL_EN
        if (stall_len < 0) $display("[TB] note: stall window %0d", stall_start);
`else
        if (stall_len + stall_start < 0) $display("[TB] note: negative stall arguments");
`endif
        reset = 1'b0;
        start = 1'b0;
    endtask

    // Unstalled expectations: issue k in cycle k+1, partial k in cycle k+11, done right after the last partial
    task automatic checkRun(input string name, input int rows, input int chunks);
        int n;
        int exp_done;
        n = rows * chunks;
        exp_done = (n == 0) ? 1 : n + 11;
        checkOutput({name, "/rd_count"}, rd_cycles.size(), n);
        checkOutput({name, "/srbv_count"}, srbv_cycles.size(), n);
        checkOutput({name, "/pv_count"}, pv_cycles.size(), n);
        for (int k = 0; k < n; k++) begin
            checkOutput({name, "/rd_cycle"}, qget(rd_cycles, k), k + 1);
            checkOutput({name, "/a_addr"}, qget(a_q, k), k);
            checkOutput({name, "/p_addr"}, qget(p_q, k), k % chunks);
            checkOutput({name, "/srbv_cycle"}, qget(srbv_cycles, k), k + 2);
            checkOutput({name, "/pv_cycle"}, qget(pv_cycles, k), k + 11);
            checkOutput({name, "/first"}, qget(pf_q, k), int'((k % chunks) == 0));
            checkOutput({name, "/last"}, qget(pl_q, k), int'((k % chunks) == chunks - 1));
            checkOutput({name, "/row"}, qget(pr_q, k), k / chunks);
        end
        checkOutput({name, "/done_count"}, done_count, 1);
        checkOutput({name, "/done_cycle"}, done_cycle, exp_done);
        checkOutput({name, "/busy_t1"}, busy_at[1], 1);
        checkOutput({name, "/busy_after_done"}, busy_at[exp_done + 1], 0);
    endtask

    initial begin
        int exp_addr[6];
        int exp_rd[6];
        int exp_pv[4];
        reset          = 1'b1;
        start          = 1'b0;
        num_rows       = '0;
        chunks_per_row = '0;
`ifdef RBV_SCHED_STALL_EN
        stall          = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_ctrl", int'({busy, done, rd_en, start_row_by_vector, partial_valid,
                                        partial_first, partial_last}), 0);
        checkOutput("reset_addr", int'({a_rd_addr, p_rd_addr}), 0);
        checkOutput("reset_row", int'(partial_row), 0);
        reset = 1'b0;

        // rows=2, chunks=3 with hand-derived timing landmarks
        applyStimulus(2, 3, 0, 0, 0, 0);
        checkRun("r2c3", 2, 3);
        checkOutput("r2c3/first_partial_t", qget(pv_cycles, 0), 11);
        checkOutput("r2c3/final_partial_t", qget(pv_cycles, 5), 16);
        checkOutput("r2c3/final_a_addr", qget(a_q, 5), 5);
        checkOutput("r2c3/done_t", done_cycle, 17);

        applyStimulus(4, 1, 0, 0, 0, 0);
        checkRun("r4c1", 4, 1);
        checkOutput("r4c1/done_after_last", done_cycle, qget(pv_cycles, 3) + 1);

        applyStimulus(0, 3, 0, 0, 0, 0);
        checkRun("r0c3", 0, 3);
        applyStimulus(2, 0, 0, 0, 0, 0);
        checkRun("r2c0", 2, 0);

        // A second start during ISSUE must not disturb the running product
        applyStimulus(2, 3, 3, 0, 0, 0);
        checkRun("repulse", 2, 3);

        // Reset in the 4th cycle: everything quiet afterwards
        applyStimulus(2, 3, 0, 4, 0, 0);
        checkOutput("midrst/ctrl_after", snap_ctrl, 0);
        checkOutput("midrst/addr_after", snap_addr, 0);
        checkOutput("midrst/partials", pv_cycles.size(), 0);
        checkOutput("midrst/done_count", done_count, 0);
        checkOutput("midrst/busy_late", busy_at[10], 0);

        applyStimulus(2, 3, 0, 0, 0, 0);
        checkRun("post_rst", 2, 3);

`ifdef RBV_SCHED_STALL_EN
        // rows=1, chunks=4, stall high in cycles 2 and 3
        applyStimulus(1, 4, 0, 0, 2, 2);
        exp_addr = '{0, 1, 1, 1, 2, 3};
        exp_rd   = '{1, 0, 0, 1, 1, 1};
        exp_pv   = '{11, 14, 15, 16};
        for (int t = 1; t <= 6; t++) begin
            checkOutput("stall/a_addr", addr_at[t], exp_addr[t-1]);
            checkOutput("stall/rd_en", rd_at[t], exp_rd[t-1]);
        end
        checkOutput("stall/pv_count", pv_cycles.size(), 4);
        for (int k = 0; k < 4; k++) begin
            checkOutput("stall/pv_cycle", qget(pv_cycles, k), exp_pv[k]);
        end
        checkOutput("stall/done_cycle", done_cycle, 17);
        checkOutput("stall/done_count", done_count, 1);
`else
        exp_addr = '{0, 1, 2, 3, 4, 5};
        exp_rd   = '{1, 1, 1, 1, 1, 1};
        exp_pv   = '{11, 12, 13, 14};
        applyStimulus(1, 4, 0, 0, 0, 0);
        for (int t = 1; t <= 4; t++) begin
            checkOutput("nostall/a_addr", addr_at[t], exp_addr[t-1]);
            checkOutput("nostall/rd_en", rd_at[t], exp_rd[t-1]);
            checkOutput("nostall/pv_cycle", qget(pv_cycles, t - 1), exp_pv[t-1]);
        end
        checkOutput("nostall/done_cycle", done_cycle, 15);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
